// File: rtl/systolic_skew_buffer.sv
`default_nettype none
// ============================================================================
// Module  : systolic_skew_buffer
// Brief   : Per-lane delay buffer that skews (MODE=0) or deskews (MODE=1) a
//           LANES-wide vector stream, with per-lane valid, frame-end last,
//           busy indication and synchronous flush.
// Option  : SKEW_ZERO_PAD_EN -- invalid lanes carry zero data.
// Revision: 1.0
// ============================================================================
module systolic_skew_buffer #(
  parameter int DATA_WIDTH = 20,
  parameter int LANES      = 6,
  parameter int MODE       = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic [DATA_WIDTH*LANES-1:0] din,
  output logic [DATA_WIDTH*LANES-1:0] dout,
  output logic [LANES-1:0]            out_lane_valid,
  output logic                        out_last,
  output logic                        busy
);

  // Both modes have their slowest lane at LANES+1 cycles; only that lane's
  // last bit is ever observed, so a single last chain of that depth is kept.
  localparam int MAX_DEPTH = LANES + 1;

  logic [LANES-1:0]     lane_busy;
  logic [MAX_DEPTH-1:0] last_q;
  logic [MAX_DEPTH-1:0] last_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int DEPTH = (MODE == 0) ? (i + 2) : (LANES + 1 - i);

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d;
    logic [DEPTH-1:0]      vld_q;
    logic [DEPTH-1:0]      vld_d;

`ifdef SKEW_ZERO_PAD_EN
    assign data_d = in_valid ? din[DATA_WIDTH*i +: DATA_WIDTH] : '0;
`else
    assign data_d = din[DATA_WIDTH*i +: DATA_WIDTH];
`endif
    assign vld_d = {vld_q[DEPTH-2:0], in_valid};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q <= '0;
        for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
      end else if (flush) begin
        vld_q <= '0;
        for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
      end else if (en) begin
        vld_q     <= vld_d;
        data_q[0] <= data_d;
        for (int k = 1; k < DEPTH; k++) data_q[k] <= data_q[k-1];
      end
    end

    assign dout[DATA_WIDTH*i +: DATA_WIDTH] = data_q[DEPTH-1];
    assign out_lane_valid[i]                = vld_q[DEPTH-1];
    assign lane_busy[i]                     = |vld_q;
  end

  assign last_d = {last_q[MAX_DEPTH-2:0], in_valid & in_last};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= '0;
    end else if (flush) begin
      last_q <= '0;
    end else if (en) begin
      last_q <= last_d;
    end
  end

  assign out_last = last_q[MAX_DEPTH-1];
  assign busy     = |lane_busy;

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_buffer.sv
`default_nettype none
// Bench for systolic_skew_buffer: SKEW and DESKEW instances share one stimulus
// stream and are compared each cycle against a history-indexed reference model.
module tb_systolic_skew_buffer;
  localparam int W  = 8;
  localparam int L  = 4;
  localparam int DW = W * L;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0, flush = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] skw_dout, dsk_dout;
  logic [L-1:0]  skw_v, dsk_v;
  logic          skw_last, dsk_last, skw_busy, dsk_busy;

  int checks = 0;
  int errors = 0;

  // Reference history: entry n is the input accepted on the n-th counted edge.
  logic          hv [0:4095];
  logic          hl [0:4095];
  logic [DW-1:0] hd [0:4095];
  int n       = 0;
  int floor_n = 0;

  systolic_skew_buffer #(.DATA_WIDTH(W), .LANES(L), .MODE(0)) u_skw (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .in_last(in_last), .din(din), .dout(skw_dout), .out_lane_valid(skw_v),
    .out_last(skw_last), .busy(skw_busy));

  systolic_skew_buffer #(.DATA_WIDTH(W), .LANES(L), .MODE(1)) u_dsk (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .in_last(in_last), .din(din), .dout(dsk_dout), .out_lane_valid(dsk_v),
    .out_last(dsk_last), .busy(dsk_busy));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Lane i of a vector accepted on edge e shows on dout after edge e+D(i)-1.
  task automatic model_exp(input int m, output logic [DW-1:0] ed, output logic [L-1:0] ev,
                           output logic el, output logic eb);
    int d, idx, lo;
    ed = '0; ev = '0; el = 1'b0; eb = 1'b0;
    for (int i = 0; i < L; i++) begin
      d   = (m == 0) ? i + 2 : L + 1 - i;
      idx = n - d + 1;
      if (idx > floor_n) begin
        ev[i] = hv[idx];
        ed[W*i +: W] = hd[idx][W*i +: W];
`ifdef SKEW_ZERO_PAD_EN
        if (!hv[idx]) ed[W*i +: W] = '0;
`endif
      end
    end
    idx = n - L;
    if (idx > floor_n) el = hv[idx] & hl[idx];
    lo = (floor_n + 1 > n - L) ? floor_n + 1 : n - L;
    for (int k = lo; k <= n; k++) if (hv[k]) eb = 1'b1;
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] ed;
    logic [L-1:0]  ev;
    logic          el, eb;
    model_exp(0, ed, ev, el, eb);
    chk({tag, " skw dout"}, 64'(skw_dout), 64'(ed));
    chk({tag, " skw valid"}, 64'(skw_v), 64'(ev));
    chk({tag, " skw last"}, 64'(skw_last), 64'(el));
    chk({tag, " skw busy"}, 64'(skw_busy), 64'(eb));
    model_exp(1, ed, ev, el, eb);
    chk({tag, " dsk dout"}, 64'(dsk_dout), 64'(ed));
    chk({tag, " dsk valid"}, 64'(dsk_v), 64'(ev));
    chk({tag, " dsk last"}, 64'(dsk_last), 64'(el));
    chk({tag, " dsk busy"}, 64'(dsk_busy), 64'(eb));
  endtask

  // Drive one cycle of inputs, take the edge, update the model, compare.
  task automatic step(input logic v, input logic l, input logic [DW-1:0] d,
                      input logic e, input logic f, input string tag);
    in_valid = v; in_last = l; din = d; en = e; flush = f;
    @(posedge clk);
    if (f) begin
      n++;
      floor_n = n;
    end else if (e) begin
      n++;
      hv[n] = v; hl[n] = l; hd[n] = d;
    end
    #1 check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int j = 0; j < k; j++) step(1'b0, 1'b0, DW'($urandom()), 1'b1, 1'b0, "idle");
  endtask

  task automatic async_reset();
    #1 rst = 1'b1;
    #1 floor_n = n;
    check_all("arst");
    chk("arst skw busy now", 64'(skw_busy), 64'd0);
    chk("arst dsk valid now", 64'(dsk_v), 64'd0);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    #2 check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single vector through SKEW, lanes emerge on edges 2..5, busy clears at 6.
    step(1'b1, 1'b0, 32'h44332211, 1'b1, 1'b0, "single");
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, "single");
    chk("tp lane0 e2", 64'({skw_v[0], skw_dout[7:0]}), 64'({1'b1, 8'h11}));
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, "single");
    chk("tp lane1 e3", 64'({skw_v[1], skw_dout[15:8]}), 64'({1'b1, 8'h22}));
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, "single");
    chk("tp lane2 e4", 64'({skw_v[2], skw_dout[23:16]}), 64'({1'b1, 8'h33}));
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, "single");
    chk("tp lane3 e5", 64'({skw_v[3], skw_dout[31:24]}), 64'({1'b1, 8'h44}));
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, "single");
    chk("tp busy e6", 64'(skw_busy), 64'd0);

    // Staggered input realigned by DESKEW on edge 5.
    for (int c = 0; c < 4; c++) begin
      b = 8'(8'hA0 + c);
      step(1'b1, 1'b0, {4{b}}, 1'b1, 1'b0, "deskew");
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, "deskew");
    chk("tp deskew aligned", 64'({dsk_v, dsk_dout}), 64'({4'hF, 32'hA3A2A1A0}));
    idle(6);

    // Two back-to-back frames; first out_last on edge 7.
    step(1'b1, 1'b0, 32'h01010101, 1'b1, 1'b0, "frame");
    step(1'b1, 1'b0, 32'h02020202, 1'b1, 1'b0, "frame");
    step(1'b1, 1'b1, 32'h03030303, 1'b1, 1'b0, "frame");
    step(1'b1, 1'b0, 32'h04040404, 1'b1, 1'b0, "frame");
    step(1'b1, 1'b1, 32'h05050505, 1'b1, 1'b0, "frame");
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, "frame");
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, "frame");
    chk("tp out_last e7", 64'({skw_last, skw_dout[31:24]}), 64'({1'b1, 8'h03}));
    idle(6);

    // Enable stalls during a frame.
    step(1'b1, 1'b0, 32'hC4C3C2C1, 1'b1, 1'b0, "stall");
    for (int j = 0; j < 12; j++)
      step(1'b0, 1'b0, '0, 1'(j % 3 == 2), 1'b0, "stall");
    idle(6);

    // Flush mid-drain, then flush with en low.
    step(1'b1, 1'b0, DW'($urandom()), 1'b1, 1'b0, "flush");
    step(1'b1, 1'b1, DW'($urandom()), 1'b1, 1'b0, "flush");
    idle(2);
    step(1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1, "flush");
    chk("tp flush skw", 64'({skw_busy, skw_last, skw_v, skw_dout}), 64'd0);
    chk("tp flush dsk", 64'({dsk_busy, dsk_last, dsk_v, dsk_dout}), 64'd0);
    step(1'b1, 1'b1, DW'($urandom()), 1'b1, 1'b0, "flush");
    step(1'b1, 1'b0, DW'($urandom()), 1'b0, 1'b1, "flush en0");
    idle(3);

    // Async reset mid-frame.
    step(1'b1, 1'b0, DW'($urandom()), 1'b1, 1'b0, "arst");
    step(1'b1, 1'b1, DW'($urandom()), 1'b1, 1'b0, "arst");
    async_reset();
    idle(6);

    // Invalid input with all-ones data.
    for (int j = 0; j < 7; j++) step(1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, "pad");

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), DW'($urandom()),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0), "rand");
      if (c == 200) async_reset();
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
